// File: rtl/key_encode83.sv
// 8-to-3 push-button encoder: synchronise, debounce and priority-encode active-low keys.
// Optional auto-repeat while a key is held is enabled with `define KEY_REPEAT_EN.
module key_encode83 #(
  parameter int DEB_CYCLES    = 240000,
  parameter int REPEAT_CYCLES = 6000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_n,
  output logic [2:0] code,
  output logic       valid,
  output logic       multi,
  output logic       held
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  localparam logic [23:0] DEB_LAST = 24'(DEB_CYCLES - 1);

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt;
`endif

  logic [7:0]  sync1, sync2, snap;
  logic [7:0]  p;
  logic [1:0]  state;
  logic [23:0] cnt;
  logic        mlat;
  logic [2:0]  enc;
  logic        enc_multi;

  assign p = ~sync2;
  // multi is only meaningful alongside the strobe; the latched value survives for repeats
  assign multi = valid & mlat;

  // Highest pressed index wins; codes run backwards so key 7 maps to 3'b000
  always_comb begin
    enc = 3'b000;
    for (int i = 0; i < 8; i++) begin
      if (snap[i]) enc = 3'(7 - i);
    end
    enc_multi = ($countones(snap) > 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 8'hFF;
      sync2 <= 8'hFF;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      snap  <= '0;
      code  <= 3'b000;
      valid <= 1'b0;
      mlat  <= 1'b0;
      held  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rcnt  <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (p != 8'h00) begin
            snap  <= p;
            cnt   <= '0;
            state <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (p == 8'h00) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (p != snap) begin
            snap <= p;
            cnt  <= '0;
          end else if (cnt == DEB_LAST) begin
            code  <= enc;
            mlat  <= enc_multi;
            valid <= 1'b1;
            held  <= 1'b1;
            cnt   <= '0;
            state <= S_HELD;
`ifdef KEY_REPEAT_EN
            rcnt  <= '0;
`endif
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        S_HELD: begin
          if (p == 8'h00) begin
            cnt   <= '0;
            state <= S_RELEASE;
          end
`ifdef KEY_REPEAT_EN
          else if (rcnt == REP_LAST) begin
            valid <= 1'b1;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
`endif
        end
        S_RELEASE: begin
          if (p != 8'h00) begin
            cnt   <= '0;
            state <= S_HELD;
`ifdef KEY_REPEAT_EN
            rcnt  <= '0;
`endif
          end else if (cnt == DEB_LAST) begin
            held  <= 1'b0;
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_encode83.sv
// Bench for key_encode83: directed scenarios plus random key traffic against a run-length model.
module tb_key_encode83;

  localparam int DEB = 4;
  localparam int REP = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_n;
  logic [2:0] code;
  logic       valid, multi, held;

  always #5 clk = ~clk;

  key_encode83 #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .code(code), .valid(valid), .multi(multi), .held(held)
  );

  int total = 0, passed = 0, fails = 0;
  int nvalid = 0;

  // reference model: input pipeline plus run lengths of identical pressed / released samples
  logic [7:0] s1m, s2m, runv;
  int         run, zrun, rc;
  logic       mheld, evalid, elat;
  logic [2:0] ecode;

  function automatic int hi(input logic [7:0] v);
    int h = 0;
    for (int i = 0; i < 8; i++) if (v[i]) h = i;
    return h;
  endfunction

  function automatic int pop(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    s1m = 8'hFF; s2m = 8'hFF; runv = 8'h00;
    run = 0; zrun = 0; rc = 0;
    mheld = 1'b0; evalid = 1'b0; elat = 1'b0; ecode = 3'b000;
  endtask

  task automatic model_edge();
    logic [7:0] p;
    if (rst) begin
      model_reset();
      return;
    end
    p = ~s2m; s2m = s1m; s1m = key_n;
    evalid = 1'b0;
    if (!mheld) begin
      if (p == 8'h00) run = 0;
      else if (run > 0 && p == runv) run++;
      else begin run = 1; runv = p; end
      if (run == DEB + 1) begin
        evalid = 1'b1;
        ecode  = 3'(7 - hi(runv));
        elat   = (pop(runv) > 1);
        mheld  = 1'b1;
        run = 0; zrun = 0; rc = 0;
      end
    end else begin
`ifdef KEY_REPEAT_EN
      if (zrun == 0 && p != 8'h00) begin
        rc++;
        if (rc == REP) begin evalid = 1'b1; rc = 0; end
      end else if (zrun > 0 && p != 8'h00) begin
        rc = 0;
      end
`endif
      if (p == 8'h00) zrun++; else zrun = 0;
      if (zrun == DEB + 1) begin mheld = 1'b0; zrun = 0; run = 0; end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, valid, evalid);
    check({tag, ".multi"}, multi, evalid & elat);
    check({tag, ".code"},  code,  ecode);
    check({tag, ".held"},  held,  mheld);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs("cyc");
      if (valid) nvalid++;
    end
  endtask

  initial begin
    int v0, lat;
    logic [7:0] val;
    rst = 1'b1; key_n = 8'hFF;
    model_reset();
    #1 check_outputs("reset");
    step(2);
    rst = 1'b0;

    // single press of key 0, then release
    key_n = 8'hFE; v0 = nvalid;
    step(12);
    check("single_count", nvalid - v0, 1);
    check("single_code", code, 3'b111);
    key_n = 8'hFF;
    step(10);
    check("single_release", held, 1'b0);

    // keys 7 and 0 together
    key_n = 8'h7E; v0 = nvalid;
    step(12);
    check("prio_count", nvalid - v0, 1);
    check("prio_code", code, 3'b000);
    key_n = 8'hFF;
    step(10);

    // press bounce must not be accepted
    v0 = nvalid;
    for (int k = 0; k < 5; k++) begin
      key_n = 8'hF7; step(2);
      key_n = 8'hFF; step(2);
    end
    step(8);
    check("bounce_count", nvalid - v0, 0);
    check("bounce_held", held, 1'b0);
    key_n = 8'hF7;
    step(12);
    check("bounce_accept", nvalid - v0, 1);
    check("bounce_code", code, 3'b100);

    // release bounce while key 3 is held
    v0 = nvalid;
    for (int k = 0; k < 5; k++) begin
      key_n = 8'hFF; step(2);
      key_n = 8'hF7; step(2);
    end
    check("relbounce_count", nvalid - v0, 0);
    check("relbounce_held", held, 1'b1);
    key_n = 8'hFF;
    step(10);
    check("relbounce_release", held, 1'b0);

    // reset two cycles into debounce
    key_n = 8'hFE; v0 = nvalid;
    step(4);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("midreset");
    step(2);
    rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (valid && lat == 0) lat = i;
    end
    check("reset_latency", lat, DEB + 3);
    check("reset_count", nvalid - v0, 1);
    key_n = 8'hFF;
    step(10);

    // random key traffic
    for (int s = 0; s < 60; s++) begin
      case ($urandom % 5)
        0: val = 8'hFF;
        1: val = 8'hFE;
        2: val = 8'h7E;
        3: val = 8'hF7;
        default: val = 8'($urandom);
      endcase
      key_n = val;
      step($urandom_range(1, 9));
    end
    key_n = 8'hFF;
    step(10);

`ifdef KEY_REPEAT_EN
    key_n = 8'hBF;
    step(7);
    check("repeat_first", valid, 1'b1);
    v0 = nvalid;
    step(40);
    check("repeat_count", nvalid - v0, 4);
    check("repeat_code", code, 3'b001);
    key_n = 8'hFF;
    step(10);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/key_encode83.md
Name: key_encode83

Overview:
- 8-to-3 encoder for the board's push-button bank; the counterpart of the 3-to-8 LED decoder.
- Synchronises and debounces eight active-low keys, then priority-encodes the pressed key into a 3-bit code.
- Emits exactly one valid strobe per debounced press.
- Code mapping is the inverse of the decoder: key index 7 -> code 3'b000, key index 0 -> code 3'b111, i.e. code = 7 - index.

Parameters:
- DEB_CYCLES, 240000, stable cycles required to accept a press or release (20 ms at 12 MHz); legal range 2..2^24-1.
- REPEAT_CYCLES, 6000000, auto-repeat period in cycles; used only when KEY_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- key_n  input  8  raw keys, active-low, asynchronous to clk.
- code  output  3  encoded key; updated only when valid is asserted; held otherwise.
- valid  output  1  one-cycle strobe; code and multi are meaningful in this cycle.
- multi  output  1  high with valid when more than one key is in the accepted snapshot.
- held  output  1  high while an accepted press has not yet been released (debounced).

Behaviour:
- Reset (async, active-high):
  - Outputs: code=3'b000, valid=0, multi=0, held=0.
  - Internal: synchroniser flops=8'hFF, counter=0, snapshot=0, state=IDLE.
  - Asserting rst mid-operation aborts any press in progress; no valid is emitted.
- Synchroniser: two flops per bit. p = ~sync2 is the pressed vector. All decisions use p only, never key_n directly.
- Counter: 24 bits; cleared on every state entry and on every snapshot change.
- Priority encoding: the highest set index in snapshot wins; code = 7 - index. multi = (popcount(snapshot) > 1).
- IDLE:
  - If p != 0: snapshot <= p, go to DEBOUNCE.
- DEBOUNCE:
  - If p == 0: go to IDLE (bounce rejected; no strobe).
  - Else if p != snapshot: snapshot <= p, restart the counter.
  - Else if counter == DEB_CYCLES-1: register code, multi and valid=1 for one cycle; set held=1; go to HELD.
  - Else: increment the counter.
- HELD:
  - If p == 0: go to RELEASE.
  - Added or removed keys with p != 0 are ignored; no new strobe until a full release.
- RELEASE:
  - If p != 0: go back to HELD (release bounce); held stays 1.
  - Else if counter == DEB_CYCLES-1: held=0, go to IDLE.
  - Else: increment the counter.
- Latency: let t0 be the first cycle in which IDLE sees p != 0, with p stable thereafter. valid is high in cycle t0+DEB_CYCLES+1. From the key_n edge this adds 2 synchroniser cycles.
- Release latency: held falls DEB_CYCLES+1 cycles after p first reads 0, provided p stays 0.
- valid is never high in two consecutive cycles. multi is 0 whenever valid is 0.

Optional Feature:
- Macro KEY_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs; it is cleared on entry to HELD and on each repeat.
  - Every REPEAT_CYCLES cycles in HELD, valid pulses again with the code and multi latched at acceptance; the encoding is not re-evaluated.
  - Entering RELEASE freezes the repeat counter. Returning to HELD from RELEASE clears it.
- Undefined: exactly one valid per accepted press; REPEAT_CYCLES is unused and no repeat counter is synthesised.

Test Plan:
- Use DEB_CYCLES=4 throughout; REPEAT_CYCLES=10 where KEY_REPEAT_EN is defined.
- Single press: drive key_n=8'hFE and hold -> exactly one valid, code=3'b111, multi=0. held rises with valid and falls 5 cycles after p returns to 0 once key_n=8'hFF.
- Priority press: drive key_n=8'h7E (keys 7 and 0) -> valid with code=3'b000, multi=1.
- Bounce rejection: toggle key_n between 8'hF7 and 8'hFF every 2 cycles for 20 cycles, then release -> no valid; held stays 0. Then hold 8'hF7 -> valid with code=3'b100.
- Release bounce while held: after acceptance of key 3, toggle key_n 8'hFF/8'hF7 every 2 cycles -> no second valid; held stays 1 until 5 stable released cycles.
- Reset mid-debounce: assert rst 2 cycles into DEBOUNCE -> all outputs 0 immediately, with no valid afterwards. After reset is released, a stable press gives the normal latency.
- KEY_REPEAT_EN defined: hold key_n=8'hBF for 40 cycles after acceptance -> valid pulses at acceptance and then every 10 cycles, each with code=3'b001.
